stack_ptr_ctrl: RTL and testbench
=================================

// Module: stack_ptr_ctrl
// PURPOSE
//  Sits directly upstream of the calculator's 6-bit up/down counter, which serves as the operand-stack pointer.
//  - Accepts push/pop/load/nop commands over a valid/ready handshake.
//  - Drives the counter's control/data inputs and watches its output to track full/empty.
//  - Generates operand-RAM strobes and reports overflow/underflow.
//  - Initialises the counter, which has no reset of its own, by loading 0.
// PARAMETERS
//  PTR_W    6   pointer width; must equal the counter width
//  MAX_PTR  63  highest legal pointer value (stack capacity); must be < 2**PTR_W
// PORTS
//  clk            in   1      rising-edge clock, shared with the counter
//  reset          in   1      synchronous, active-high reset
//  cmd_valid      in   1      command present
//  cmd_op         in   2      00 nop, 01 push, 10 pop, 11 load
//  cmd_data       in   PTR_W  pointer value for load
//  cmd_ready      out  1      block can accept a command (high only in IDLE)
//  ctr_control    out  3      to counter: 000 hold, 100 load, 010 inc1, 011 dec1
//  ctr_data       out  PTR_W  to counter data_in
//  ctr_q          in   PTR_W  from counter data_out (current pointer)
//  mem_we         out  1      operand RAM write strobe (push)
//  mem_re         out  1      operand RAM read strobe (pop)
//  mem_addr       out  PTR_W  operand RAM address
//  done           out  1      one-cycle pulse: command finished
//  err_overflow   out  1      one-cycle pulse with done: push when full, or load > MAX_PTR
//  err_underflow  out  1      one-cycle pulse with done: pop when empty
//  empty          out  1      combinational: ctr_q == 0
//  full           out  1      combinational: ctr_q == MAX_PTR
// BEHAVIOUR
//  FSM states: INIT, IDLE, EXEC, SETTLE. Reset has priority over everything.
//  - reset forces state to INIT.
//  - done, err_overflow and err_underflow are registered and cleared to 0 on reset.
//  INIT:
//  - ctr_control=100 and ctr_data=0 while reset is held and for exactly 1 cycle after release.
//  - Then go to IDLE.
//  - cmd_ready=0; mem_we and mem_re are 0.
//  IDLE:
//  - cmd_ready=1, ctr_control=000.
//  - On cmd_valid at a rising edge: capture cmd_op, cmd_data, and the full/empty status. Go to EXEC.
//  EXEC (1 cycle, acts on the captured command):
//  - push, not full: ctr_control=010; mem_we=1; mem_addr=ctr_q (pre-increment).
//  - pop, not empty: ctr_control=011; no strobe in this cycle.
//  - load, cmd_data <= MAX_PTR: ctr_control=100; ctr_data=captured cmd_data.
//  - Rejected commands and nop: ctr_control=000; no strobes; the error is flagged for SETTLE.
//  - Always go to SETTLE.
//  SETTLE (1 cycle; ctr_q now reflects the update):
//  - ctr_control=000; done=1.
//  - Flagged error: err_overflow or err_underflow = 1.
//  - Successful pop: mem_re=1, mem_addr=ctr_q (post-decrement = old top entry).
//  - Go to IDLE.
//  Timing:
//  - Accept at edge N; counter updates at edge N+1; done is high in cycle N+2.
//  - cmd_ready returns high 1 cycle after done.
//  - Throughput: 1 command per 3 cycles.
//  Boundaries:
//  - The counter never wraps: pointer range is 0..MAX_PTR.
//  - A rejected command leaves ctr_q unchanged.
//  - A command held valid while cmd_ready=0 is not consumed.
//  - Reset in EXEC or SETTLE aborts the command: no done pulse, no strobes, pointer reloaded to 0.
//  - mem_addr=0 whenever no strobe is active.
// TESTING
//  1. Reset 2 cycles, then release:
//     -> ctr_control=100/ctr_data=0 for 3 cycles, ctr_q=0, empty=1, cmd_ready=1.
//  2. Push x3, cmd_valid held high:
//     -> mem_we at mem_addr 0, 1, 2; done 3 times, 3 cycles apart; ctr_q=3.
//  3. From ctr_q=3, pop:
//     -> ctr_control=011, then mem_re with mem_addr=2; ctr_q=2.
//  4. Pop at ctr_q=0:
//     -> err_underflow=1 and done=1 in the same cycle; ctr_control stays 000; ctr_q stays 0.
//  5. Load 63, then push:
//     -> full=1, err_overflow=1, no mem_we, ctr_q=63.
//     With MAX_PTR=40, load 50 -> err_overflow=1, ctr_q unchanged.
//  6. Assert reset during EXEC of a push:
//     -> no done pulse; counter reloaded to 0; first command after release accepted normally.

Source files
------------

// File: rtl/stack_ptr_ctrl.sv
// Operand-stack pointer controller: drives an external 6-bit up/down counter and the operand
// RAM strobes from push/pop/load/nop commands, reporting overflow and underflow.
module stack_ptr_ctrl #(
   parameter int unsigned PTR_W   = 6,
   parameter int unsigned MAX_PTR = 63
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [PTR_W-1:0] cmd_data,
   output logic             cmd_ready,
   output logic [2:0]       ctr_control,
   output logic [PTR_W-1:0] ctr_data,
   input  logic [PTR_W-1:0] ctr_q,
   output logic             mem_we,
   output logic             mem_re,
   output logic [PTR_W-1:0] mem_addr,
   output logic             done,
   output logic             err_overflow,
   output logic             err_underflow,
   output logic             empty,
   output logic             full
);

   localparam logic [PTR_W-1:0] MaxPtr = PTR_W'(MAX_PTR);

   localparam logic [1:0] OpPush = 2'b01;
   localparam logic [1:0] OpPop  = 2'b10;
   localparam logic [1:0] OpLoad = 2'b11;

   localparam logic [2:0] CtlHold = 3'b000;
   localparam logic [2:0] CtlLoad = 3'b100;
   localparam logic [2:0] CtlInc  = 3'b010;
   localparam logic [2:0] CtlDec  = 3'b011;

   typedef enum logic [1:0] {StInit, StIdle, StExec, StSettle} state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [PTR_W-1:0] data_q, data_d;
   logic             full_cap_q, full_cap_d;
   logic             empty_cap_q, empty_cap_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             pop_ok_q, pop_ok_d;

   logic push_ok, pop_ok, load_ok;

   assign empty = (ctr_q == '0);
   assign full  = (ctr_q == MaxPtr);

   assign done          = done_q;
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;

   // Decisions use the status captured at acceptance, not the live counter value.
   assign push_ok = (op_q == OpPush) && !full_cap_q;
   assign pop_ok  = (op_q == OpPop) && !empty_cap_q;
   assign load_ok = (op_q == OpLoad) && (32'(data_q) <= MAX_PTR);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      full_cap_d  = full_cap_q;
      empty_cap_d = empty_cap_q;
      done_d      = 1'b0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      pop_ok_d    = 1'b0;
      cmd_ready   = 1'b0;
      ctr_control = CtlHold;
      ctr_data    = '0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_addr    = '0;

      unique case (state_q)
         StInit: begin
            ctr_control = CtlLoad;
            state_d     = StIdle;
         end
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d        = cmd_op;
               data_d      = cmd_data;
               full_cap_d  = full;
               empty_cap_d = empty;
               state_d     = StExec;
            end
         end
         StExec: begin
            if (push_ok) begin
               ctr_control = CtlInc;
               mem_we      = 1'b1;
               mem_addr    = ctr_q;
            end else if (pop_ok) begin
               ctr_control = CtlDec;
            end else if (load_ok) begin
               ctr_control = CtlLoad;
               ctr_data    = data_q;
            end
            done_d   = 1'b1;
            ovf_d    = ((op_q == OpPush) && full_cap_q) || ((op_q == OpLoad) && !load_ok);
            unf_d    = (op_q == OpPop) && empty_cap_q;
            pop_ok_d = pop_ok;
            state_d  = StSettle;
         end
         StSettle: begin
            // Counter has already decremented, so ctr_q addresses the old top entry.
            if (pop_ok_q) begin
               mem_re   = 1'b1;
               mem_addr = ctr_q;
            end
            state_d = StIdle;
         end
         default: state_d = StInit;
      endcase

      // Reset aborts any command in flight and keeps the counter loading zero.
      if (reset) begin
         cmd_ready   = 1'b0;
         ctr_control = CtlLoad;
         ctr_data    = '0;
         mem_we      = 1'b0;
         mem_re      = 1'b0;
         mem_addr    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StInit;
         op_q        <= 2'b00;
         data_q      <= '0;
         full_cap_q  <= 1'b0;
         empty_cap_q <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         pop_ok_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         full_cap_q  <= full_cap_d;
         empty_cap_q <= empty_cap_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         pop_ok_q    <= pop_ok_d;
      end
   end

endmodule

// File: tb/tb_stack_ptr_ctrl.sv
// Bench for stack_ptr_ctrl: behavioural counters stand in for the real one; a scoreboard of
// expected completions and RAM strobes is checked by a negedge monitor.
module tb_stack_ptr_ctrl;

   typedef struct packed {
      logic       ovf;
      logic       unf;
      logic [5:0] ptr;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [5:0] cmd_data;
   logic       cmd_ready;
   logic [2:0] ctr_control;
   logic [5:0] ctr_data;
   logic [5:0] ctr_q;
   logic       mem_we, mem_re;
   logic [5:0] mem_addr;
   logic       done, err_overflow, err_underflow, empty, full;

   logic       b_valid;
   logic [1:0] b_op;
   logic [5:0] b_data;
   logic       b_ready;
   logic [2:0] b_ctl;
   logic [5:0] b_cdata;
   logic [5:0] b_q;
   logic       b_we, b_re;
   logic [5:0] b_addr;
   logic       b_done, b_ovf, b_unf, b_empty, b_full;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   logic [5:0] we_q[$];
   logic [5:0] re_q[$];
   int   done_cyc[$];
   logic [5:0] model_ptr;

   always #5 clk = ~clk;

   stack_ptr_ctrl #(.PTR_W(6), .MAX_PTR(63)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .cmd_ready(cmd_ready), .ctr_control(ctr_control), .ctr_data(ctr_data), .ctr_q(ctr_q),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .done(done),
      .err_overflow(err_overflow), .err_underflow(err_underflow), .empty(empty), .full(full)
   );

   stack_ptr_ctrl #(.PTR_W(6), .MAX_PTR(40)) dut40 (
      .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_op(b_op), .cmd_data(b_data),
      .cmd_ready(b_ready), .ctr_control(b_ctl), .ctr_data(b_cdata), .ctr_q(b_q),
      .mem_we(b_we), .mem_re(b_re), .mem_addr(b_addr), .done(b_done),
      .err_overflow(b_ovf), .err_underflow(b_unf), .empty(b_empty), .full(b_full)
   );

   // Reset-less up/down counters, as in the calculator datapath.
   always @(posedge clk) begin
      case (ctr_control)
         3'b100:  ctr_q <= ctr_data;
         3'b010:  ctr_q <= ctr_q + 6'd1;
         3'b011:  ctr_q <= ctr_q - 6'd1;
         default: ctr_q <= ctr_q;
      endcase
      case (b_ctl)
         3'b100:  b_q <= b_cdata;
         3'b010:  b_q <= b_q + 6'd1;
         3'b011:  b_q <= b_q - 6'd1;
         default: b_q <= b_q;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (reset) begin
         chk("strobes_in_reset", {29'd0, mem_we, mem_re, done}, 32'd0);
      end else begin
         if (done) begin
            chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("err_overflow", 32'(err_overflow), 32'(e.ovf));
               chk("err_underflow", 32'(err_underflow), 32'(e.unf));
               chk("ptr_after", 32'(ctr_q), 32'(e.ptr));
               chk("ctl_settle", 32'(ctr_control), 32'd0);
            end
            done_cyc.push_back(cyc);
         end else begin
            chk("err_without_done", {30'd0, err_overflow, err_underflow}, 32'd0);
         end
         if (mem_we) begin
            chk("we_expected", 32'(we_q.size() > 0), 32'd1);
            if (we_q.size() > 0) chk("we_addr", 32'(mem_addr), 32'(we_q.pop_front()));
         end
         if (mem_re) begin
            chk("re_expected", 32'(re_q.size() > 0), 32'd1);
            if (re_q.size() > 0) chk("re_addr", 32'(mem_addr), 32'(re_q.pop_front()));
         end
         if (!mem_we && !mem_re) chk("addr_idle_zero", 32'(mem_addr), 32'd0);
      end
   end

   // Issues one command and returns at the negedge of its EXEC cycle.
   task automatic send(input logic [1:0] op, input logic [5:0] data, input bit hold);
      bit   ok;
      exp_t e;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_timeout", 32'(ok), 32'd1);
      e.ovf = 1'b0;
      e.unf = 1'b0;
      case (op)
         2'b01: if (model_ptr == 6'd63) e.ovf = 1'b1;
                else begin we_q.push_back(model_ptr); model_ptr = model_ptr + 6'd1; end
         2'b10: if (model_ptr == 6'd0) e.unf = 1'b1;
                else begin model_ptr = model_ptr - 6'd1; re_q.push_back(model_ptr); end
         2'b11: model_ptr = data;
         default: ;
      endcase
      e.ptr = model_ptr;
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic settle();
      bit ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_timeout", 32'(ok), 32'd1);
   endtask

   task automatic send_b(input logic [5:0] data, input logic exp_ovf, input logic [5:0] exp_ptr);
      bit ok = 1'b0;
      @(posedge clk); #1;
      b_valid = 1'b1;
      b_op    = 2'b11;
      b_data  = data;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("b_accept_timeout", 32'(ok), 32'd1);
      @(posedge clk); #1;
      b_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (b_done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("b_done_timeout", 32'(ok), 32'd1);
      chk("b_err_overflow", 32'(b_ovf), 32'(exp_ovf));
      chk("b_ptr_after", 32'(b_q), 32'(exp_ptr));
      chk("b_full", 32'(b_full), 32'(exp_ptr == 6'd40));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 6'd0;
      b_valid   = 1'b0;
      b_op      = 2'b00;
      b_data    = 6'd0;
      model_ptr = 6'd0;

      // Reset held, then one INIT cycle after release: counter loading 0 throughout.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_ctl", 32'(ctr_control), 32'h4);
         chk("rst_ctr_data", 32'(ctr_data), 32'd0);
         chk("rst_ready", 32'(cmd_ready), 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("init_ctl", 32'(ctr_control), 32'h4);
      chk("init_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("idle_ctl", 32'(ctr_control), 32'd0);
      chk("idle_ptr", 32'(ctr_q), 32'd0);
      chk("idle_empty", 32'(empty), 32'd1);

      // Three pushes with cmd_valid held high.
      done_cyc.delete();
      send(2'b01, 6'd0, 1'b1);
      send(2'b01, 6'd0, 1'b1);
      send(2'b01, 6'd0, 1'b0);
      settle();
      chk("push3_dones", 32'(done_cyc.size()), 32'd3);
      if (done_cyc.size() == 3) begin
         chk("push3_spacing_a", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
         chk("push3_spacing_b", 32'(done_cyc[2] - done_cyc[1]), 32'd3);
      end
      chk("push3_ptr", 32'(ctr_q), 32'd3);

      // Pop from 3.
      send(2'b10, 6'd0, 1'b0);
      chk("pop_exec_ctl", 32'(ctr_control), 32'h3);
      chk("pop_exec_re", 32'(mem_re), 32'd0);
      settle();
      chk("pop_ptr", 32'(ctr_q), 32'd2);

      // Nop, drain to zero, then underflow.
      send(2'b00, 6'd9, 1'b0);
      chk("nop_exec_ctl", 32'(ctr_control), 32'd0);
      settle();
      send(2'b10, 6'd0, 1'b0);
      settle();
      send(2'b10, 6'd0, 1'b0);
      settle();
      chk("drained_empty", 32'(empty), 32'd1);
      send(2'b10, 6'd0, 1'b0);
      chk("underflow_exec_ctl", 32'(ctr_control), 32'd0);
      settle();
      chk("underflow_ptr", 32'(ctr_q), 32'd0);

      // Load 63 then overflowing push.
      send(2'b11, 6'd63, 1'b0);
      chk("load_exec_ctl", 32'(ctr_control), 32'h4);
      chk("load_exec_data", 32'(ctr_data), 32'd63);
      settle();
      chk("load63_full", 32'(full), 32'd1);
      send(2'b01, 6'd0, 1'b0);
      chk("overflow_exec_we", 32'(mem_we), 32'd0);
      chk("overflow_exec_ctl", 32'(ctr_control), 32'd0);
      settle();
      chk("overflow_ptr", 32'(ctr_q), 32'd63);

      // Smaller capacity instance: load beyond MAX_PTR is rejected.
      send_b(6'd20, 1'b0, 6'd20);
      send_b(6'd50, 1'b1, 6'd20);
      send_b(6'd40, 1'b0, 6'd40);

      // Reset during EXEC of a push aborts it.
      send(2'b11, 6'd5, 1'b0);
      settle();
      send(2'b01, 6'd0, 1'b0);
      #1;
      reset = 1'b1;
      exp_q.delete();
      we_q.delete();
      re_q.delete();
      model_ptr = 6'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      settle();
      chk("abort_ptr", 32'(ctr_q), 32'd0);
      chk("abort_empty", 32'(empty), 32'd1);
      send(2'b01, 6'd0, 1'b0);
      settle();
      chk("after_abort_ptr", 32'(ctr_q), 32'd1);

      chk("queues_drained", 32'(exp_q.size() + we_q.size() + re_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
